pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard-and-forwarding controller for the 5-stage pipeline.
- Replaces the separate combinational hazard-detection and forwarding units, and adds four things they lack:
  - its own registered EX/MEM/WB destination-tag pipeline;
  - branch-taken flush of IF/ID and ID/EX;
  - a stall counter for multi-cycle EX operations;
  - EX operand forwarding muxes.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers. Drives PC/IF_ID write enables, the ID/EX bubble select and the ALU operands.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- MULTI_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_rs  in  REG_AW  rs field of the ID instruction.
- id_rt  in  REG_AW  rt field of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dst  in  REG_AW  destination register after the RegDest mux.
- id_reg_write  in  1  ID control RegWrite.
- id_mem_read  in  1  ID control MemRead.
- id_multi  in  1  ID instruction is a multi-cycle EX op.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_rs_data  in  DATA_W  ID/EX Read_Data_1.
- ex_rt_data  in  DATA_W  ID/EX Read_Data_2.
- mem_alu_result  in  DATA_W  EX/MEM ALU result.
- wb_write_data  in  DATA_W  writeback mux output.
- pc_write  out  1  1 = PC may update.
- if_id_write  out  1  1 = IF/ID may load.
- if_id_flush  out  1  1 = IF/ID loads a NOP.
- id_ex_bubble  out  1  1 = ID/EX control fields forced to 0.
- fwd_a  out  2  operand A select: 00 reg, 01 WB, 10 MEM.
- fwd_b  out  2  operand B select, same encoding as fwd_a.
- ex_op_a  out  DATA_W  forwarded operand A.
- ex_op_b  out  DATA_W  forwarded operand B.
- ex_busy  out  1  multi-cycle op is occupying EX.

Behaviour:
- Tag pipeline: EX, MEM and WB entries, each {valid, rs, rt, dst, reg_write, mem_read, multi}.
  - EX additionally holds use_rs and use_rt.
  - Advances every cycle.
  - EX loads the ID fields, or all-zero when id_ex_bubble=1.
  - MEM loads EX except while ex_busy=1; in that case MEM loads invalid and EX holds.
- Reset (rst_n=0 at a clk edge): all tags invalid, busy counter 0.
  - Resulting outputs: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=00, ex_busy=0.
- Hazard definition: a "hit" on X requires tag.valid, tag.reg_write, tag.dst==X and X!=0.
- Forwarding is combinational from the tags:
  - fwd_a=10 on a MEM hit on EX.rs with EX.use_rs; otherwise 01 on a WB hit; otherwise 00.
  - MEM has priority over WB.
  - fwd_b is identical on EX.rt.
  - ex_op_a/b mux the data inputs per the select; 11 is never generated.
- Load-use stall: an EX entry with mem_read hits id_rs (with id_use_rs) or id_rt (with id_use_rt).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle.
- Multi-cycle:
  - When an entry with multi=1 enters EX, the counter loads MULTI_LAT-1.
  - ex_busy = (counter!=0).
  - While busy: pc_write=0, if_id_write=0, EX holds, a bubble is sent to MEM.
  - The counter decrements each cycle; the op leaves EX on the cycle the counter reaches 0.
  - A multi-cycle op occupies EX for exactly MULTI_LAT cycles.
- Branch flush: ex_branch_taken=1 gives if_id_flush=1 and id_ex_bubble=1 in the same cycle, with pc_write=1 and if_id_write=1.
  - Flush overrides load-use stall.
  - ex_branch_taken is ignored while ex_busy=1.
- Simultaneous load-use and busy: busy wins; load-use is re-evaluated after busy clears.
- Reset mid multi-op: the counter clears and the op is dropped.
- Stall signals are combinational from the registered tags and ID inputs; no extra latency.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the tag struct/field widths;
  - REG_ZERO.
- One sub-module: pipe_fwd_mux (DATA_W), instantiated twice for operands A and B.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 (back-to-back): next cycle fwd_a=10, ex_op_a=mem_alu_result=0x0000_0007, no stall.
- add r3 followed after two cycles by a reader of r3: fwd_a=01, ex_op_a=wb_write_data=0x1234_5678. With a MEM hit on r3 also present, 10 is chosen.
- lw r2 then add r4,r2,r1: exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then fwd_b=01 carries the load data.
- Multi-cycle op with MULTI_LAT=4: ex_busy high for 3 cycles, pc_write low for 3 cycles, MEM receives 3 bubbles. With ex_branch_taken pulsed mid-op, no flush occurs.
- ex_branch_taken=1 while a load-use condition is also present: if_id_flush=1, id_ex_bubble=1, pc_write=1. Writes to r0 never produce fwd≠00.
- rst_n=0 asserted during a busy op: next cycle ex_busy=0, fwd_a=fwd_b=00, pc_write=1, and all tags are invalid.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds the destination-tag layout, the forward-select encodings and the tag-hit rule.
package pipe_hazard_ctrl_pkg;

  // Tag register fields are sized for the widest supported register address.
  localparam int unsigned TAG_AW  = 8;
  localparam int unsigned BUSY_CW = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [TAG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rs;
    logic [TAG_AW-1:0] rt;
    logic [TAG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
    logic              multi;
    logic              use_rs;
    logic              use_rt;
  } tag_t;

  // An entry produces register r when it is live, writes, targets r, and r is not r0.
  function automatic logic tag_hit(input tag_t t, input logic [TAG_AW-1:0] r);
    return t.valid && t.reg_write && (t.dst == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_fwd_mux.sv
// EX operand select: register file value, WB result or MEM result.
module pipe_fwd_mux
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] op_c
);

  always_comb begin
    op_c = reg_data;
    case (sel)
      FWD_WB:  op_c = wb_data;
      FWD_MEM: op_c = mem_data;
      default: op_c = reg_data;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX/MEM/WB tag pipeline,
// load-use stall, branch flush, multi-cycle EX occupancy and EX operand forwarding.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MULTI_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_multi,
  input  logic              ex_branch_taken,
  input  logic [DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic              ex_busy
);

  tag_t               id_tag;
  tag_t               ex_tag;
  tag_t               mem_tag;
  tag_t               wb_tag;
  logic [BUSY_CW-1:0] busy_cnt;
  logic               load_use;
  logic               flush;

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = 1'b1;
    id_tag.rs        = TAG_AW'(id_rs);
    id_tag.rt        = TAG_AW'(id_rt);
    id_tag.dst       = TAG_AW'(id_dst);
    id_tag.reg_write = id_reg_write;
    id_tag.mem_read  = id_mem_read;
    id_tag.multi     = id_multi;
    id_tag.use_rs    = id_use_rs;
    id_tag.use_rt    = id_use_rt;
  end

  // Stall/flush decisions; an occupied EX masks both load-use and branch flush.
  always_comb begin
    ex_busy  = (busy_cnt != '0);
    load_use = !ex_busy && ex_tag.mem_read &&
               ((id_use_rs && tag_hit(ex_tag, id_tag.rs)) ||
                (id_use_rt && tag_hit(ex_tag, id_tag.rt)));
    flush        = !ex_busy && ex_branch_taken;
    pc_write     = !ex_busy && (flush || !load_use);
    if_id_write  = !ex_busy && (flush || !load_use);
    if_id_flush  = flush;
    id_ex_bubble = flush || load_use;
  end

  // MEM result is newer than WB, so it wins when both produce the operand.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (ex_tag.use_rs && tag_hit(mem_tag, ex_tag.rs))     fwd_a = FWD_MEM;
    else if (ex_tag.use_rs && tag_hit(wb_tag, ex_tag.rs)) fwd_a = FWD_WB;
    if (ex_tag.use_rt && tag_hit(mem_tag, ex_tag.rt))     fwd_b = FWD_MEM;
    else if (ex_tag.use_rt && tag_hit(wb_tag, ex_tag.rt)) fwd_b = FWD_WB;
  end

  // While busy, EX holds its op, MEM takes bubbles and the counter runs down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_tag   <= '0;
      mem_tag  <= '0;
      wb_tag   <= '0;
      busy_cnt <= '0;
    end else begin
      wb_tag <= mem_tag;
      if (ex_busy) begin
        mem_tag  <= '0;
        busy_cnt <= busy_cnt - BUSY_CW'(1);
      end else begin
        mem_tag  <= ex_tag;
        ex_tag   <= id_ex_bubble ? '0 : id_tag;
        busy_cnt <= (!id_ex_bubble && id_multi) ? BUSY_CW'(MULTI_LAT - 1) : '0;
      end
    end
  end

  // Empty slots are always all-zero, so stale fields can never alias a real tag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((ex_tag.valid  || (ex_tag  == '0)) &&
              (mem_tag.valid || (mem_tag == '0)) &&
              (wb_tag.valid  || (wb_tag  == '0)));
    end
  end

  pipe_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .sel      (fwd_a),
    .reg_data (ex_rs_data),
    .wb_data  (wb_write_data),
    .mem_data (mem_alu_result),
    .op_c     (ex_op_a)
  );

  pipe_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .sel      (fwd_b),
    .reg_data (ex_rt_data),
    .wb_data  (wb_write_data),
    .mem_data (mem_alu_result),
    .op_c     (ex_op_b)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle/reset sequences,
// then random traffic against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int MULTI_LAT = 4;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, id_dst;
  logic              id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_multi;
  logic              ex_branch_taken;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, mem_alu_result, wb_write_data;
  logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_busy;
  logic [1:0]        fwd_a, fwd_b;
  logic [DATA_W-1:0] ex_op_a, ex_op_b;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MULTI_LAT(MULTI_LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_dst          (id_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_multi        (id_multi),
    .ex_branch_taken (ex_branch_taken),
    .ex_rs_data      (ex_rs_data),
    .ex_rt_data      (ex_rt_data),
    .mem_alu_result  (mem_alu_result),
    .wb_write_data   (wb_write_data),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .ex_op_a         (ex_op_a),
    .ex_op_b         (ex_op_b),
    .ex_busy         (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst, rs, rt, urs, urt, dst, rw, mr, mul, br;
    int chk, pcw, bub, fl, fa, fb, busy;
  } vec_t;

  typedef struct {
    int valid, rs, rt, dst, use_rs, use_rt, rw, mr, multi;
  } minst_t;

  vec_t   vecs[$];
  minst_t m_pipe[3];
  minst_t empty_inst;
  int     m_age;

  function automatic vec_t mk(input int rst, rs, rt, urs, urt, dst, rw, mr, mul, br,
                              input int chk, pcw, bub, fl, fa, fb, busy);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.dst = dst;
    v.rw = rw; v.mr = mr; v.mul = mul; v.br = br; v.chk = chk; v.pcw = pcw;
    v.bub = bub; v.fl = fl; v.fa = fa; v.fb = fb; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_data(input int sel, input logic [31:0] reg_d);
    if (sel == 2) return mem_alu_result;
    if (sel == 1) return wb_write_data;
    return reg_d;
  endfunction

  task automatic check_outs(input string tag, input int pcw, bub, fl, fa, fb, busy);
    check({tag, " pc_write"},     32'(pc_write),     32'(pcw));
    check({tag, " if_id_write"},  32'(if_id_write),  32'(pcw));
    check({tag, " if_id_flush"},  32'(if_id_flush),  32'(fl));
    check({tag, " id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
    check({tag, " fwd_a"},        32'(fwd_a),        32'(fa));
    check({tag, " fwd_b"},        32'(fwd_b),        32'(fb));
    check({tag, " ex_op_a"},      ex_op_a,           sel_data(fa, ex_rs_data));
    check({tag, " ex_op_b"},      ex_op_b,           sel_data(fb, ex_rt_data));
    check({tag, " ex_busy"},      32'(ex_busy),      32'(busy));
  endtask

  // One cycle: drive ID/branch inputs after the falling edge, let them settle.
  task automatic step(input int rst, rs, rt, urs, urt, dst, rw, mr, mul, br);
    @(negedge clk);
    rst_n           = 1'(rst);
    id_rs           = REG_AW'(rs);
    id_rt           = REG_AW'(rt);
    id_use_rs       = 1'(urs);
    id_use_rt       = 1'(urt);
    id_dst          = REG_AW'(dst);
    id_reg_write    = 1'(rw);
    id_mem_read     = 1'(mr);
    id_multi        = 1'(mul);
    ex_branch_taken = 1'(br);
    #1;
  endtask

  function automatic int m_writes(input minst_t s, input int r);
    return (s.valid != 0 && s.rw != 0 && s.dst == r && r != 0) ? 1 : 0;
  endfunction

  function automatic int m_fwd(input int use_op, input int r);
    if (use_op == 0) return 0;
    if (m_writes(m_pipe[1], r) != 0) return 2;
    if (m_writes(m_pipe[2], r) != 0) return 1;
    return 0;
  endfunction

  initial begin
    empty_inst = '{default: 0};
    rst_n = 1'b0;
    ex_rs_data     = 32'hA0A0_A0A0;
    ex_rt_data     = 32'hB0B0_B0B0;
    mem_alu_result = 32'h0000_0007;
    wb_write_data  = 32'h1234_5678;

    //           rst rs rt urs urt dst rw mr mul br  chk pcw bub fl fa fb busy
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // add r3,r1,r2
    vecs.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // sub r4,r3,r5
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // add r3
    vecs.push_back(mk(1, 1, 0, 1, 0, 6, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 1, 0, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // reads r3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 8, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 2, 0)); // MEM beats WB
    vecs.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // lw r2
    vecs.push_back(mk(1, 1, 2, 1, 1, 4, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0)); // load-use
    vecs.push_back(mk(1, 1, 2, 1, 1, 4, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // lw r2
    vecs.push_back(mk(1, 2, 1, 1, 1, 5, 1, 0, 0, 1,  1, 1, 1, 1, 0, 0, 0)); // flush wins
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // write r0
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // lw r0
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].dst,
           vecs[i].rw, vecs[i].mr, vecs[i].mul, vecs[i].br);
      if (vecs[i].chk != 0)
        check_outs($sformatf("row%0d", i), vecs[i].pcw, vecs[i].bub, vecs[i].fl,
                   vecs[i].fa, vecs[i].fb, vecs[i].busy);
    end

    // Multi-cycle op with a branch pulse in the middle of its occupancy.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 10, 1, 0, 1, 0);  check_outs("mul_a", 1, 0, 0, 0, 0, 0);
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, 0); check_outs("mul_b", 0, 0, 0, 0, 0, 1);
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, 1); check_outs("mul_c", 0, 0, 0, 0, 0, 1);
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, 0); check_outs("mul_d", 0, 0, 0, 0, 0, 1);
    step(1, 10, 0, 1, 0, 11, 1, 0, 0, 0); check_outs("mul_e", 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   check_outs("mul_f", 1, 0, 0, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   check_outs("mul_g", 1, 0, 0, 0, 0, 0);

    // Reset while a multi-cycle load-like op occupies EX.
    step(1, 0, 0, 0, 0, 12, 1, 1, 1, 0);  check_outs("rst_a", 1, 0, 0, 0, 0, 0);
    step(0, 12, 0, 1, 0, 13, 1, 0, 0, 0); check_outs("rst_b", 0, 0, 0, 0, 0, 1);
    step(1, 12, 0, 1, 0, 13, 1, 0, 0, 0); check_outs("rst_c", 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   check_outs("rst_d", 1, 0, 0, 0, 0, 0);

    // Random traffic against the instruction-level model.
    m_pipe[0] = empty_inst; m_pipe[1] = empty_inst; m_pipe[2] = empty_inst;
    m_age = 0;
    for (int c = 0; c < 3000; c++) begin
      minst_t nin;
      int busy, lu, fl, bub, pcw, br, rst;
      nin.valid  = 1;
      nin.rs     = int'($urandom_range(0, 3));
      nin.rt     = int'($urandom_range(0, 3));
      nin.use_rs = int'($urandom_range(0, 1));
      nin.use_rt = int'($urandom_range(0, 1));
      nin.dst    = int'($urandom_range(0, 3));
      nin.rw     = ($urandom_range(0, 3) != 0) ? 1 : 0;
      nin.mr     = ($urandom_range(0, 3) == 0) ? 1 : 0;
      nin.multi  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      br         = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rst        = (c == 0 || $urandom_range(0, 59) == 0) ? 0 : 1;
      step(rst, nin.rs, nin.rt, nin.use_rs, nin.use_rt, nin.dst, nin.rw, nin.mr,
           nin.multi, br);
      ex_rs_data     = $urandom;
      ex_rt_data     = $urandom;
      mem_alu_result = $urandom;
      wb_write_data  = $urandom;
      #1;
      busy = (m_pipe[0].valid != 0 && m_pipe[0].multi != 0 && m_age < MULTI_LAT - 1) ? 1 : 0;
      lu   = (busy == 0 && m_pipe[0].mr != 0 &&
              ((nin.use_rs != 0 && m_writes(m_pipe[0], nin.rs) != 0) ||
               (nin.use_rt != 0 && m_writes(m_pipe[0], nin.rt) != 0))) ? 1 : 0;
      fl   = (busy == 0 && br != 0) ? 1 : 0;
      bub  = (fl != 0 || lu != 0) ? 1 : 0;
      pcw  = (busy == 0 && (fl != 0 || lu == 0)) ? 1 : 0;
      if (c > 0)
        check_outs($sformatf("rnd%0d", c), pcw, bub, fl,
                   m_fwd(m_pipe[0].use_rs, m_pipe[0].rs),
                   m_fwd(m_pipe[0].use_rt, m_pipe[0].rt), busy);
      @(posedge clk);
      if (rst == 0) begin
        m_pipe[0] = empty_inst; m_pipe[1] = empty_inst; m_pipe[2] = empty_inst;
        m_age = 0;
      end else begin
        m_pipe[2] = m_pipe[1];
        if (busy != 0) begin
          m_pipe[1] = empty_inst;
          m_age++;
        end else begin
          m_pipe[1] = m_pipe[0];
          m_pipe[0] = (bub != 0) ? empty_inst : nin;
          m_age = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
